// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port used by the fetch stage.
// The master holds req/addr until the slave returns ack with the word.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC, variable-latency imem port, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt/bubble_cnt outputs.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          stall_F,
   input  logic          stall_D,
   input  logic          pcsrc_D,
   input  logic [31:0]   pcbranch_D,
   input  logic          jump_D,
   input  logic [31:0]   pcjump_D,
   fetch_stage_if.master imem,
   output logic [31:0]   instr_D,
   output logic [31:0]   pcplus4_D,
   output logic          valid_D
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]   fetch_cnt,
   output logic [31:0]   bubble_cnt
`endif
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_KILL,
      S_FULL
   } state_t;

   state_t      r_state, w_state_nx;
   logic [31:0] r_pc, w_pc_nx;
   logic [31:0] r_hold, w_hold_nx;
   logic [31:0] r_tgt, w_tgt_nx;
   logic [31:0] r_instr, w_instr_nx;
   logic [31:0] r_pcp4, w_pcp4_nx;
   logic        r_valid, w_valid_nx;
   logic        w_stall, w_redir;
   logic        w_ld_v, w_ld_b;
   logic [31:0] w_target, w_pc4;

   assign w_stall  = stall_F | stall_D;
   assign w_redir  = r_valid & ~w_stall & (jump_D | pcsrc_D);
   assign w_target = (jump_D ? pcjump_D : pcbranch_D) & ~32'h3;
   assign w_pc4    = r_pc + 32'd4;

   assign imem.imem_req  = (r_state == S_REQ) | (r_state == S_KILL);
   assign imem.imem_addr = r_pc;
   assign instr_D        = r_instr;
   assign pcplus4_D      = r_pcp4;
   assign valid_D        = r_valid;

   always_comb begin
      w_state_nx = r_state;
      w_pc_nx    = r_pc;
      w_hold_nx  = r_hold;
      w_tgt_nx   = r_tgt;
      w_instr_nx = r_instr;
      w_pcp4_nx  = r_pcp4;
      w_valid_nx = r_valid;
      w_ld_v     = 1'b0;
      w_ld_b     = 1'b0;
      unique case (r_state)
         S_IDLE: w_state_nx = S_REQ;
         S_REQ: begin
            if (w_redir) begin
               w_ld_b = 1'b1;
               if (imem.imem_ack) begin
                  w_pc_nx = w_target;
               end else begin
                  w_tgt_nx   = w_target;
                  w_state_nx = S_KILL;
               end
            end else if (imem.imem_ack) begin
               w_pc_nx = w_pc4;
               if (w_stall) begin
                  w_hold_nx  = imem.imem_rdata;
                  w_state_nx = S_FULL;
               end else begin
                  w_ld_v     = 1'b1;
                  w_instr_nx = imem.imem_rdata;
                  w_pcp4_nx  = w_pc4;
               end
            end else if (!w_stall) begin
               w_ld_b = 1'b1;
            end
         end
         // Squashed request still in flight: drop its data, then retarget.
         S_KILL: begin
            w_ld_b = ~w_stall;
            if (imem.imem_ack) begin
               w_pc_nx    = r_tgt;
               w_state_nx = S_REQ;
            end
         end
         S_FULL: begin
            if (w_redir) begin
               w_ld_b     = 1'b1;
               w_pc_nx    = w_target;
               w_state_nx = S_REQ;
            end else if (!w_stall) begin
               w_ld_v     = 1'b1;
               w_instr_nx = r_hold;
               w_pcp4_nx  = r_pc;
               w_state_nx = S_REQ;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
      if (w_ld_b) begin
         w_instr_nx = 32'h0;
         w_pcp4_nx  = 32'h0;
         w_valid_nx = 1'b0;
      end
      if (w_ld_v) w_valid_nx = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_hold  <= 32'h0;
         r_tgt   <= 32'h0;
         r_instr <= 32'h0;
         r_pcp4  <= 32'h0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_pc    <= w_pc_nx;
         r_hold  <= w_hold_nx;
         r_tgt   <= w_tgt_nx;
         r_instr <= w_instr_nx;
         r_pcp4  <= w_pcp4_nx;
         r_valid <= w_valid_nx;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt, r_bubble_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fetch_cnt  <= 32'h0;
         r_bubble_cnt <= 32'h0;
      end else begin
         if (w_ld_v) r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (w_ld_b) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
   end

   assign fetch_cnt  = r_fetch_cnt;
   assign bubble_cnt = r_bubble_cnt;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage against a queue-based fetch model.
// Directed sections pin reset, stall, redirect, wrap and async reset.
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall_F, stall_D, pcsrc_D, jump_D;
   logic [31:0] pcbranch_D, pcjump_D;
   logic [31:0] instr_D, pcplus4_D;
   logic        valid_D;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt, bubble_cnt;
`endif

   fetch_stage_if imem ();

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .stall_F    (stall_F),
      .stall_D    (stall_D),
      .pcsrc_D    (pcsrc_D),
      .pcbranch_D (pcbranch_D),
      .jump_D     (jump_D),
      .pcjump_D   (pcjump_D),
      .imem       (imem),
      .instr_D    (instr_D),
      .pcplus4_D  (pcplus4_D),
      .valid_D    (valid_D)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt  (fetch_cnt),
      .bubble_cnt (bubble_cnt)
`endif
   );

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] hw(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Model: a fetch address, an optional squash, a buffer of words
   // fetched while Decode was stalled, and the word shown to Decode.
   bit          m_run, m_kill, m_valid;
   logic [31:0] m_pc, m_tgt, m_instr, m_p4;
   logic [31:0] m_buf[$];
   int unsigned m_nv, m_nb;

   function automatic logic m_req();
      return m_run && (m_buf.size() == 0);
   endfunction

   task automatic model_reset();
      m_run = 0; m_kill = 0; m_valid = 0;
      m_pc = 32'h0; m_tgt = 32'h0; m_instr = 32'h0; m_p4 = 32'h0;
      m_buf.delete();
      m_nv = 0; m_nb = 0;
   endtask

   task automatic bubble();
      m_instr = 32'h0; m_p4 = 32'h0; m_valid = 0; m_nb++;
   endtask

   task automatic deliver(input logic [31:0] w, input logic [31:0] p4);
      m_instr = w; m_p4 = p4; m_valid = 1; m_nv++;
   endtask

   task automatic model_step();
      bit st, rd, ack;
      logic [31:0] tg;
      if (!m_run) begin
         m_run = 1;
         return;
      end
      st  = stall_F || stall_D;
      rd  = m_valid && !st && (jump_D || pcsrc_D);
      tg  = (jump_D ? pcjump_D : pcbranch_D) & 32'hFFFF_FFFC;
      ack = imem.imem_ack;
      if (m_buf.size() != 0) begin
         if (rd) begin
            m_buf.delete(); bubble(); m_pc = tg;
         end else if (!st) begin
            deliver(m_buf.pop_front(), m_pc);
         end
      end else if (m_kill) begin
         if (!st) m_nb++;
         if (ack) begin
            m_kill = 0; m_pc = m_tgt;
         end
      end else if (rd) begin
         bubble();
         if (ack) m_pc = tg;
         else begin
            m_kill = 1; m_tgt = tg;
         end
      end else if (ack) begin
         if (st) m_buf.push_back(imem.imem_rdata);
         else deliver(imem.imem_rdata, m_pc + 32'd4);
         m_pc = m_pc + 32'd4;
      end else if (!st) begin
         bubble();
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_req", {31'b0, imem.imem_req}, {31'b0, m_req()});
         chk("imem_addr", imem.imem_addr, m_pc);
         chk("valid_D", {31'b0, valid_D}, {31'b0, m_valid});
         chk("instr_D", instr_D, m_instr);
         chk("pcplus4_D", pcplus4_D, m_p4);
`ifdef FETCH_PERF_CNT_EN
         chk("fetch_cnt", fetch_cnt, m_nv);
         chk("bubble_cnt", bubble_cnt, m_nb);
`endif
      end
   end

   int lat = -1;
   int lmin = 0, lmax = 0;

   // Memory slave: random latency per request, ack decided after each edge.
   task automatic tick();
      @(posedge clk);
      if (reset_n) model_step();
      #1;
      if (reset_n && imem.imem_req) begin
         if (lat < 0) lat = int'($urandom_range(lmax, lmin));
         imem.imem_ack = (lat == 0);
         lat = lat - 1;
      end else begin
         imem.imem_ack = 1'b0;
      end
      imem.imem_rdata = imem.imem_ack ? hw(imem.imem_addr) : $urandom;
   endtask

   task automatic idle_in();
      stall_F = 0; stall_D = 0; pcsrc_D = 0; jump_D = 0;
      pcbranch_D = 32'h0; pcjump_D = 32'h0;
   endtask

   task automatic wait_valid(input string name);
      for (int k = 0; k < 20 && valid_D !== 1'b1; k++) tick();
      chk(name, {31'b0, valid_D}, 32'h1);
   endtask

   initial begin
      logic [31:0] a;
      idle_in();
      reset_n = 1'b0;
      imem.imem_ack = 1'b0;
      imem.imem_rdata = 32'h0;
      model_reset();
      #2;
      chk_en = 1'b1;
      tick(); tick();
      chk("rst_req", {31'b0, imem.imem_req}, 32'h0);
      chk("rst_valid", {31'b0, valid_D}, 32'h0);
      chk("rst_addr", imem.imem_addr, 32'h0);
      reset_n = 1'b1;

      // Zero-wait memory from reset
      lmin = 0; lmax = 0;
      tick();
      chk("zw_addr0", imem.imem_addr, 32'h0);
      chk("zw_req0", {31'b0, imem.imem_req}, 32'h1);
      tick();
      chk("zw_addr1", imem.imem_addr, 32'h4);
      chk("zw_p4_1", pcplus4_D, 32'h4);
      chk("zw_ins_1", instr_D, 32'h1357_6420);
      tick();
      chk("zw_addr2", imem.imem_addr, 32'h8);
      chk("zw_p4_2", pcplus4_D, 32'h8);

      // Stall both stages while 0x10 is acked
      for (int k = 0; k < 20 && imem.imem_addr !== 32'h10; k++) tick();
      chk("st_reach", imem.imem_addr, 32'h10);
      stall_F = 1; stall_D = 1;
      tick();
      chk("st_full_req", {31'b0, imem.imem_req}, 32'h0);
      tick(); tick(); tick();
      stall_F = 0; stall_D = 0;
      tick();
      chk("st_instr", instr_D, hw(32'h10));
      chk("st_p4", pcplus4_D, 32'h14);
      chk("st_addr", imem.imem_addr, 32'h14);

      // Branch with a fetch still in flight
      lmin = 3; lmax = 3;
      wait_valid("br_wait_valid");
      pcsrc_D = 1; pcbranch_D = 32'h100;
      tick();
      idle_in();
      for (int k = 0; k < 10 && imem.imem_addr !== 32'h100; k++) begin
         chk("br_no_valid", {31'b0, valid_D}, 32'h0);
         tick();
      end
      chk("br_addr", imem.imem_addr, 32'h100);

      // Jump wins over branch; a stalled redirect is ignored
      lmin = 0; lmax = 0;
      wait_valid("jb_wait_valid");
      jump_D = 1; pcjump_D = 32'h200; pcsrc_D = 1; pcbranch_D = 32'h300;
      tick();
      idle_in();
      chk("jb_addr", imem.imem_addr, 32'h200);
      wait_valid("jb_wait_valid2");
      jump_D = 1; pcjump_D = 32'h200; pcsrc_D = 1; pcbranch_D = 32'h300;
      stall_D = 1;
      a = imem.imem_addr;
      tick();
      chk("jb_stall_addr", imem.imem_addr, a + 32'd4);
      idle_in();
      tick(); tick();

      // Address wrap at the top of memory
      wait_valid("wr_wait_valid");
      jump_D = 1; pcjump_D = 32'hFFFF_FFFE;
      tick();
      idle_in();
      chk("wr_addr", imem.imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("wr_p4", pcplus4_D, 32'h0);
      chk("wr_instr", instr_D, hw(32'hFFFF_FFFC));
      chk("wr_next", imem.imem_addr, 32'h0);

      // Asynchronous reset while a fetch waits for ack
      lmin = 3; lmax = 3;
      for (int k = 0; k < 10 && !(imem.imem_req && !imem.imem_ack); k++) tick();
      chk("ar_pending", {31'b0, imem.imem_req}, 32'h1);
      #2;
      reset_n = 1'b0;
      imem.imem_ack = 1'b0;
      lat = -1;
      model_reset();
      #1;
      chk("ar_req", {31'b0, imem.imem_req}, 32'h0);
      chk("ar_addr", imem.imem_addr, 32'h0);
      chk("ar_valid", {31'b0, valid_D}, 32'h0);
      chk("ar_instr", instr_D, 32'h0);
      chk("ar_p4", pcplus4_D, 32'h0);
      tick(); tick();
      reset_n = 1'b1;

      // Random traffic
      for (int p = 0; p < 6; p++) begin
         int sp, rp;
         lmin = (p % 3 == 0) ? 0 : 1;
         lmax = lmin + p % 4;
         sp = 10 + 8 * p;
         rp = 5 + 4 * p;
         for (int c = 0; c < 400; c++) begin
            tick();
            stall_F = ($urandom_range(99) < sp);
            stall_D = ($urandom_range(99) < sp);
            pcsrc_D = ($urandom_range(99) < rp);
            jump_D  = ($urandom_range(99) < rp / 2);
            pcbranch_D = $urandom;
            pcjump_D   = $urandom;
         end
      end
      idle_in();
      tick(); tick();
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
